// File: rtl/t16_fetch.sv
// Instruction fetch and program-load stage for the T16 core: owns the
// instruction memory and PC, and sequences download, fill, run and halt.
module t16_fetch #(
    parameter int                 PC_W       = 5,
    parameter int                 INSTR_W    = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR  = 16'h0000,
    parameter logic [INSTR_W-1:0] HALT_INSTR = 16'hFFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    input  logic               start,
    input  logic               stall,
    input  logic [PC_W-1:0]    nxtpc,
    output logic [PC_W-1:0]    cpc,
    output logic [INSTR_W-1:0] instr,
    output logic               core_en,
    output logic               halted,
    output logic [15:0]        retired
);
    localparam int DEPTH = 2**PC_W;

    typedef enum logic [2:0] {S_LOAD, S_FILL, S_READY, S_RUN, S_HALT} state_t;

    logic [INSTR_W-1:0] imem [DEPTH];

    state_t             state_q, state_d;
    logic [PC_W-1:0]    cpc_q, cpc_d;
    logic [PC_W-1:0]    waddr_q, waddr_d;
    logic [15:0]        ret_q, ret_d;
    logic               lrdy_q, halted_q;
    logic               we;
    logic [INSTR_W-1:0] wdata;
    logic [INSTR_W-1:0] fetch;
    logic               exec;

    // Zero-latency read so the core sees the word at cpc in the same cycle.
    assign fetch = imem[cpc_q];
    assign exec  = (state_q == S_RUN) && !stall && (fetch != HALT_INSTR);

    assign core_en    = exec;
    assign instr      = exec ? fetch : NOP_INSTR;
    assign cpc        = cpc_q;
    assign retired    = ret_q;
    assign load_ready = lrdy_q;
    assign halted     = halted_q;

    always_comb begin
        state_d = state_q;
        cpc_d   = cpc_q;
        waddr_d = waddr_q;
        ret_d   = ret_q;
        we      = 1'b0;
        wdata   = load_data;
        case (state_q)
            S_LOAD: begin
                if (load_valid && lrdy_q) begin
                    we      = 1'b1;
                    waddr_d = waddr_q + 1'b1;
                    // The final slot ends the download regardless of load_last.
                    if (&waddr_q)       state_d = S_READY;
                    else if (load_last) state_d = S_FILL;
                end
            end
            S_FILL: begin
                we      = 1'b1;
                wdata   = NOP_INSTR;
                waddr_d = waddr_q + 1'b1;
                if (&waddr_q) state_d = S_READY;
            end
            S_READY: begin
                cpc_d = '0;
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                if (!stall) begin
                    if (fetch == HALT_INSTR) begin
                        state_d = S_HALT;
                    end else begin
                        cpc_d = nxtpc;
                        if (ret_q != 16'hFFFF) ret_d = ret_q + 16'd1;
                    end
                end
            end
            S_HALT: begin
                if (start) begin
                    cpc_d   = '0;
                    ret_d   = '0;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_LOAD;
            cpc_q    <= '0;
            waddr_q  <= '0;
            ret_q    <= '0;
            lrdy_q   <= 1'b1;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cpc_q    <= cpc_d;
            waddr_q  <= waddr_d;
            ret_q    <= ret_d;
            lrdy_q   <= (state_d == S_LOAD);
            halted_q <= (state_d == S_HALT);
        end
    end

    // Memory has no reset; contents survive rst until overwritten.
    always_ff @(posedge clk) begin
        if (we && !rst) imem[waddr_q] <= wdata;
    end
endmodule

// File: tb/tb_t16_fetch.sv
// Directed bench for t16_fetch: load, fill, run, stall, branch, halt, reset.
module tb_t16_fetch;
    logic        clk = 1'b0;
    logic        rst, load_valid, load_last, start, stall;
    logic [15:0] load_data;
    logic [4:0]  nxtpc, cpc;
    logic        load_ready, core_en, halted;
    logic [15:0] instr, retired;
    logic        ovr_en;
    logic [4:0]  ovr;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    // Core model: sequential next PC unless a branch target is forced.
    assign nxtpc = ovr_en ? ovr : cpc + 5'd1;

    t16_fetch dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_last(load_last), .start(start), .stall(stall),
        .nxtpc(nxtpc), .cpc(cpc), .instr(instr), .core_en(core_en),
        .halted(halted), .retired(retired)
    );

    function automatic logic [15:0] w(int i);
        return (i == 4) ? 16'hFFFF : (16'hA000 | 16'(i));
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0; #1;
        checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL reset_load_ready got=%b exp=1", load_ready); end
        checks++; if (cpc !== 5'd0) begin failures++; $display("FAIL reset_cpc got=%0d exp=0", cpc); end
        checks++; if (retired !== 16'd0) begin failures++; $display("FAIL reset_retired got=%0d exp=0", retired); end
        checks++; if (core_en !== 1'b0 || halted !== 1'b0 || instr !== 16'h0000) begin
            failures++; $display("FAIL reset_outputs got core_en=%b halted=%b instr=%h exp 0/0/0000", core_en, halted, instr); end
    endtask

    task automatic test_load_short();
        int bad;
        load_valid = 1'b1; load_data = 16'h1111; load_last = 1'b0;
        tick(); load_data = 16'h2222;
        tick(); load_data = 16'h3333; load_last = 1'b1;
        tick(); load_valid = 1'b0; load_last = 1'b0; #1;
        checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL fill_load_ready got=%b exp=0", load_ready); end
        bad = 0;
        repeat (28) begin tick(); #1; if (load_ready !== 1'b0 || core_en !== 1'b0) bad++; end
        // Last FILL cycle: start must be ignored.
        start = 1'b1;
        tick(); start = 1'b0; #1;
        checks++; if (bad != 0) begin failures++; $display("FAIL fill_quiet got=%0d bad cycles exp=0", bad); end
        checks++; if (core_en !== 1'b0 || halted !== 1'b0) begin
            failures++; $display("FAIL fill_len_start_ignored got core_en=%b halted=%b exp 0/0", core_en, halted); end
        start = 1'b1;
        tick(); start = 1'b0; #1;
        checks++; if (cpc !== 5'd0 || core_en !== 1'b1 || instr !== 16'h1111) begin
            failures++; $display("FAIL ready_start got cpc=%0d core_en=%b instr=%h exp 0/1/1111", cpc, core_en, instr); end
        repeat (3) tick(); #1;
        checks++; if (cpc !== 5'd3 || core_en !== 1'b1 || instr !== 16'h0000) begin
            failures++; $display("FAIL filled_nop got cpc=%0d core_en=%b instr=%h exp 3/1/0000", cpc, core_en, instr); end
        repeat (4) tick(); #1;
        checks++; if (cpc !== 5'd7 || retired !== 16'd7) begin
            failures++; $display("FAIL run_to_7 got cpc=%0d retired=%0d exp 7/7", cpc, retired); end
        rst = 1'b1;
        tick(); rst = 1'b0; #1;
        checks++; if (cpc !== 5'd0 || retired !== 16'd0 || load_ready !== 1'b1 || core_en !== 1'b0 || instr !== 16'h0000) begin
            failures++; $display("FAIL rst_mid_run got cpc=%0d retired=%0d load_ready=%b core_en=%b instr=%h exp 0/0/1/0/0000",
                                 cpc, retired, load_ready, core_en, instr); end
    endtask

    task automatic test_load_full();
        int bad;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            load_valid = 1'b1; load_data = w(i); load_last = 1'b0; #1;
            if (load_ready !== 1'b1) bad++;
            tick();
        end
        load_valid = 1'b1; load_data = 16'hDEAD; load_last = 1'b1; #1;
        checks++; if (bad != 0) begin failures++; $display("FAIL full_load_ready got=%0d stalled words exp=0", bad); end
        checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL word33_ready got=%b exp=0", load_ready); end
        start = 1'b1;
        tick(); start = 1'b0; load_valid = 1'b0; load_last = 1'b0; #1;
        checks++; if (cpc !== 5'd0 || core_en !== 1'b1 || instr !== w(0)) begin
            failures++; $display("FAIL full_no_fill got cpc=%0d core_en=%b instr=%h exp 0/1/%h", cpc, core_en, instr, w(0)); end
    endtask

    task automatic test_halt();
        int en_cnt;
        en_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (cpc !== 5'(i) || instr !== w(i)) begin
                failures++; $display("FAIL seq_pc%0d got cpc=%0d instr=%h exp %0d/%h", i, cpc, instr, i, w(i)); end
            if (core_en === 1'b1) en_cnt++;
            tick(); #1;
        end
        checks++; if (cpc !== 5'd4 || core_en !== 1'b0 || instr !== 16'h0000 || halted !== 1'b0) begin
            failures++; $display("FAIL halt_fetch got cpc=%0d core_en=%b instr=%h halted=%b exp 4/0/0000/0", cpc, core_en, instr, halted); end
        tick(); #1;
        checks++; if (halted !== 1'b1 || cpc !== 5'd4 || retired !== 16'd4 || core_en !== 1'b0) begin
            failures++; $display("FAIL halted got halted=%b cpc=%0d retired=%0d core_en=%b exp 1/4/4/0", halted, cpc, retired, core_en); end
        checks++; if (en_cnt != 4) begin failures++; $display("FAIL core_en_count got=%0d exp=4", en_cnt); end
        stall = 1'b1;
        tick(); stall = 1'b0; #1;
        checks++; if (halted !== 1'b1 || cpc !== 5'd4) begin
            failures++; $display("FAIL halt_hold got halted=%b cpc=%0d exp 1/4", halted, cpc); end
    endtask

    task automatic test_stall_branch();
        start = 1'b1;
        tick(); start = 1'b0; #1;
        checks++; if (cpc !== 5'd0 || retired !== 16'd0 || core_en !== 1'b1 || halted !== 1'b0) begin
            failures++; $display("FAIL restart got cpc=%0d retired=%0d core_en=%b halted=%b exp 0/0/1/0", cpc, retired, core_en, halted); end
        tick(); tick();
        stall = 1'b1; #1;
        checks++; if (cpc !== 5'd2 || core_en !== 1'b0 || instr !== 16'h0000) begin
            failures++; $display("FAIL stall1 got cpc=%0d core_en=%b instr=%h exp 2/0/0000", cpc, core_en, instr); end
        tick(); #1;
        checks++; if (cpc !== 5'd2 || core_en !== 1'b0 || retired !== 16'd2) begin
            failures++; $display("FAIL stall2 got cpc=%0d core_en=%b retired=%0d exp 2/0/2", cpc, core_en, retired); end
        tick(); stall = 1'b0; #1;
        checks++; if (cpc !== 5'd2 || core_en !== 1'b1 || instr !== w(2) || retired !== 16'd2) begin
            failures++; $display("FAIL stall_release got cpc=%0d core_en=%b instr=%h retired=%0d exp 2/1/%h/2", cpc, core_en, instr, retired, w(2)); end
        tick(); ovr_en = 1'b1; ovr = 5'd5; #1;
        tick(); #1;
        checks++; if (cpc !== 5'd5 || retired !== 16'd4 || instr !== w(5)) begin
            failures++; $display("FAIL jump5 got cpc=%0d retired=%0d instr=%h exp 5/4/%h", cpc, retired, instr, w(5)); end
        ovr = 5'd1; start = 1'b1;
        tick(); start = 1'b0; ovr = 5'd31; #1;
        checks++; if (cpc !== 5'd1 || retired !== 16'd5) begin
            failures++; $display("FAIL branch_to_1 got cpc=%0d retired=%0d exp 1/5", cpc, retired); end
        tick(); ovr = 5'd0; #1;
        checks++; if (cpc !== 5'd31 || instr !== w(31)) begin
            failures++; $display("FAIL pc31 got cpc=%0d instr=%h exp 31/%h", cpc, instr, w(31)); end
        tick(); ovr_en = 1'b0; #1;
        checks++; if (cpc !== 5'd0 || retired !== 16'd7 || instr !== w(0)) begin
            failures++; $display("FAIL wrap got cpc=%0d retired=%0d instr=%h exp 0/7/%h", cpc, retired, instr, w(0)); end
    endtask

    initial begin
        rst = 1'b1; load_valid = 1'b0; load_last = 1'b0; load_data = 16'h0000;
        start = 1'b0; stall = 1'b0; ovr_en = 1'b0; ovr = 5'd0;
        test_reset();
        test_load_short();
        test_load_full();
        test_halt();
        test_stall_branch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
